// File: rtl/seg_pkg.sv
// Shared definitions for the segment extractor: field widths, FSM encoding
// and the run descriptor record that travels through the descriptor FIFO.
package seg_pkg;

  localparam int POS_W  = 10;
  localparam int SIZE_W = 11;
  localparam int COL_W  = 8;
  localparam int DESC_W = POS_W + SIZE_W + COL_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } seg_state_t;

  typedef struct packed {
    logic [POS_W-1:0]  pos;
    logic [SIZE_W-1:0] size;
    logic [COL_W-1:0]  col;
  } seg_desc_t;

  // Assemble a descriptor from its three fields.
  function automatic seg_desc_t make_desc(input logic [POS_W-1:0]  pos,
                                          input logic [SIZE_W-1:0] size,
                                          input logic [COL_W-1:0]  col);
    seg_desc_t d;
    d.pos  = pos;
    d.size = size;
    d.col  = col;
    return d;
  endfunction

endpackage

// File: rtl/seg_fifo.sv
// Synchronous first-word-fallthrough FIFO with registered full/empty flags.
// A push while full is still taken when a pop happens in the same cycle.
// The read data is forced to zero while the FIFO is empty.
module seg_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 29
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_ZERO = (PTR_W+1)'(0);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic [PTR_W:0]   count_nxt_s;
  logic             full_r;
  logic             empty_r;
  logic             wr_en_s;
  logic             rd_en_s;

  // Qualify push/pop against the flags and derive the next occupancy.
  always_comb begin
    rd_en_s     = pop && !empty_r;
    wr_en_s     = push && (!full_r || rd_en_s);
    count_nxt_s = count_r;
    if (wr_en_s && !rd_en_s) begin
      count_nxt_s = count_r + CNT_ONE;
    end else if (!wr_en_s && rd_en_s) begin
      count_nxt_s = count_r - CNT_ONE;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Pointer, occupancy and flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= CNT_ZERO;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == DEPTH_C);
      empty_r <= (count_nxt_s == CNT_ZERO);
    end
  end

  // Storage array; contents are only ever observed through non-empty slots.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign pop_data = empty_r ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];
  assign full     = full_r;
  assign empty    = empty_r;

endmodule

// File: rtl/segment_extractor.sv
// Run-length segment extractor: turns a stream of pixel colours into
// (start, length, colour) descriptors for every non-background run on a line.
// Runs are closed at line end; a single-pixel run that starts on the last
// pixel of a line while another run is being closed is emitted one cycle
// later from the FLUSH state, so at most one descriptor is pushed per cycle.
import seg_pkg::*;

module segment_extractor #(
  parameter int LINE_LEN   = 1024,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_valid,
  input  logic [COL_W-1:0]  pix_col,
  output logic              pix_ready,
  output logic              seg_valid,
  input  logic              seg_ready,
  output logic [POS_W-1:0]  seg_pos,
  output logic [SIZE_W-1:0] seg_size,
  output logic [COL_W-1:0]  seg_col,
  output logic [POS_W-1:0]  line_pos
);

  localparam logic [POS_W-1:0]  LAST_POS = POS_W'(LINE_LEN - 1);
  localparam logic [SIZE_W-1:0] SIZE_ONE = 11'd1;

  seg_state_t        state_r;
  logic [POS_W-1:0]  start_r;
  logic [SIZE_W-1:0] len_r;
  logic [COL_W-1:0]  col_r;
  logic [POS_W-1:0]  line_pos_r;

  logic              accept_s;
  logic              eol_s;
  logic              bg_s;
  logic              push_s;
  seg_desc_t         push_desc_s;
  logic [DESC_W-1:0] push_bits_s;
  logic [DESC_W-1:0] pop_bits_s;
  seg_desc_t         pop_desc_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;

  assign pix_ready = rst && !fifo_full_s && (state_r != ST_FLUSH);
  assign accept_s  = pix_valid && pix_ready;
  assign eol_s     = (line_pos_r == LAST_POS);
  assign bg_s      = (pix_col == 8'd0);

  // Decide whether a descriptor is closed this cycle and what it holds.
  always_comb begin
    push_s      = 1'b0;
    push_desc_s = make_desc(start_r, len_r, col_r);
    case (state_r)
      ST_IDLE: begin
        if (accept_s && !bg_s && eol_s) begin
          push_s      = 1'b1;
          push_desc_s = make_desc(line_pos_r, SIZE_ONE, pix_col);
        end else begin
          push_s = 1'b0;
        end
      end
      ST_RUN: begin
        if (accept_s && (pix_col == col_r)) begin
          push_s      = eol_s;
          push_desc_s = make_desc(start_r, len_r + SIZE_ONE, col_r);
        end else if (accept_s) begin
          push_s = 1'b1;
        end else begin
          push_s = 1'b0;
        end
      end
      ST_FLUSH: begin
        push_s = !fifo_full_s;
      end
      default: begin
        push_s = 1'b0;
      end
    endcase
  end

  // Run-tracking FSM and line position counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      start_r    <= {POS_W{1'b0}};
      len_r      <= {SIZE_W{1'b0}};
      col_r      <= {COL_W{1'b0}};
      line_pos_r <= {POS_W{1'b0}};
    end else begin
      if (accept_s) begin
        line_pos_r <= eol_s ? {POS_W{1'b0}} : line_pos_r + 10'd1;
      end
      case (state_r)
        ST_IDLE: begin
          if (accept_s && !bg_s && !eol_s) begin
            state_r <= ST_RUN;
            start_r <= line_pos_r;
            len_r   <= SIZE_ONE;
            col_r   <= pix_col;
          end
        end
        ST_RUN: begin
          if (accept_s) begin
            if (pix_col == col_r) begin
              if (eol_s) begin
                state_r <= ST_IDLE;
              end else begin
                len_r <= len_r + SIZE_ONE;
              end
            end else if (bg_s) begin
              state_r <= ST_IDLE;
            end else begin
              // A new colour on the last pixel cannot be pushed alongside
              // the run being closed, so it waits in FLUSH.
              state_r <= eol_s ? ST_FLUSH : ST_RUN;
              start_r <= line_pos_r;
              len_r   <= SIZE_ONE;
              col_r   <= pix_col;
            end
          end
        end
        ST_FLUSH: begin
          if (!fifo_full_s) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign push_bits_s = push_desc_s;

  seg_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DESC_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (push_bits_s),
    .pop       (seg_ready),
    .pop_data  (pop_bits_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  assign pop_desc_s = seg_desc_t'(pop_bits_s);
  assign seg_valid  = !fifo_empty_s;
  assign seg_pos    = pop_desc_s.pos;
  assign seg_size   = pop_desc_s.size;
  assign seg_col    = pop_desc_s.col;
  assign line_pos   = line_pos_r;

endmodule

// File: tb/tb_segment_extractor.sv
// Directed bench for segment_extractor with a 1024-pixel line and 4-deep FIFO.
module tb_segment_extractor;

  logic        clk;
  logic        rst;
  logic        pix_valid;
  logic [7:0]  pix_col;
  logic        pix_ready;
  logic        seg_valid;
  logic        seg_ready;
  logic [9:0]  seg_pos;
  logic [10:0] seg_size;
  logic [7:0]  seg_col;
  logic [9:0]  line_pos;

  int n_checks = 0;
  int n_errors = 0;
  logic [28:0] got_q[$];

  segment_extractor #(.LINE_LEN(1024), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .pix_valid (pix_valid),
    .pix_col   (pix_col),
    .pix_ready (pix_ready),
    .seg_valid (seg_valid),
    .seg_ready (seg_ready),
    .seg_pos   (seg_pos),
    .seg_size  (seg_size),
    .seg_col   (seg_col),
    .line_pos  (line_pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every descriptor that will be consumed at the next rising edge.
  always @(negedge clk) begin
    if (rst && seg_valid && seg_ready) got_q.push_back({seg_pos, seg_size, seg_col});
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [28:0] desc(input int pos, input int size, input int col);
    logic [9:0]  p;
    logic [10:0] s;
    logic [7:0]  c;
    p = 10'(pos);
    s = 11'(size);
    c = 8'(col);
    return {p, s, c};
  endfunction

  function automatic logic [7:0] pix_of(input int mode, input int pos);
    logic [7:0] c;
    c = 8'd0;
    case (mode)
      1: if (pos >= 100 && pos <= 199) c = 8'd1;
      2: begin
        if (pos >= 50 && pos <= 99) c = 8'd2;
        else if (pos >= 100 && pos <= 199) c = 8'd1;
      end
      3: c = 8'd3;
      4: begin
        if (pos >= 1000 && pos <= 1022) c = 8'd1;
        else if (pos == 1023) c = 8'd2;
      end
      5: c = (pos % 2 == 0) ? 8'd1 : 8'd2;
      default: c = 8'd0;
    endcase
    return c;
  endfunction

  // Offer one pixel and hold it until accepted (bounded wait).
  task automatic send_pix(input logic [7:0] c);
    int guard;
    guard = 0;
    pix_valid = 1'b1;
    pix_col   = c;
    @(negedge clk);
    while (!pix_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!pix_ready) check_eq("pix_wait", {31'd0, pix_ready}, 32'd1);
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    pix_col   = 8'd0;
  endtask

  task automatic send_range(input int mode, input int from, input int to);
    for (int p = from; p <= to; p++) send_pix(pix_of(mode, p));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst       = 1'b0;
    pix_valid = 1'b0;
    pix_col   = 8'd0;
    seg_ready = 1'b1;
    idle_cycles(3);
    @(negedge clk);
    check_eq("rst_pix_ready", {31'd0, pix_ready}, 32'd0);
    check_eq("rst_seg_valid", {31'd0, seg_valid}, 32'd0);
    check_eq("rst_line_pos", {22'd0, line_pos}, 32'd0);
    check_eq("rst_desc", {3'd0, seg_pos, seg_size, seg_col}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle_cycles(2);

    // Single colour-1 run, two lines.
    got_q.delete();
    send_range(1, 0, 1023);
    send_range(1, 0, 1023);
    idle_cycles(6);
    check_eq("t1_count", got_q.size(), 32'd2);
    if (got_q.size() >= 2) begin
      check_eq("t1_desc0", {3'd0, got_q[0]}, {3'd0, desc(100, 100, 1)});
      check_eq("t1_desc1", {3'd0, got_q[1]}, {3'd0, desc(100, 100, 1)});
    end
    check_eq("t1_line_pos", {22'd0, line_pos}, 32'd0);

    // Adjacent colours 2 then 1.
    got_q.delete();
    send_range(2, 0, 1023);
    idle_cycles(6);
    check_eq("t2_count", got_q.size(), 32'd2);
    if (got_q.size() >= 2) begin
      check_eq("t2_desc0", {3'd0, got_q[0]}, {3'd0, desc(50, 50, 2)});
      check_eq("t2_desc1", {3'd0, got_q[1]}, {3'd0, desc(100, 100, 1)});
    end

    // Whole line one colour: nothing until the last pixel.
    got_q.delete();
    send_range(3, 0, 1022);
    idle_cycles(3);
    check_eq("t3_early_count", got_q.size(), 32'd0);
    check_eq("t3_early_valid", {31'd0, seg_valid}, 32'd0);
    check_eq("t3_line_pos_1023", {22'd0, line_pos}, 32'd1023);
    send_range(3, 1023, 1023);
    idle_cycles(4);
    check_eq("t3_count", got_q.size(), 32'd1);
    if (got_q.size() >= 1) check_eq("t3_desc", {3'd0, got_q[0]}, {3'd0, desc(0, 1024, 3)});
    check_eq("t3_line_pos", {22'd0, line_pos}, 32'd0);

    // Colour change on the last pixel: FLUSH cycle blocks input.
    got_q.delete();
    send_range(4, 0, 1023);
    @(negedge clk);
    check_eq("t4_flush_ready", {31'd0, pix_ready}, 32'd0);
    @(negedge clk);
    check_eq("t4_after_ready", {31'd0, pix_ready}, 32'd1);
    idle_cycles(4);
    check_eq("t4_count", got_q.size(), 32'd2);
    if (got_q.size() >= 2) begin
      check_eq("t4_desc0", {3'd0, got_q[0]}, {3'd0, desc(1000, 23, 1)});
      check_eq("t4_desc1", {3'd0, got_q[1]}, {3'd0, desc(1023, 1, 2)});
    end

    // Back-pressure with alternating colours.
    got_q.delete();
    seg_ready = 1'b0;
    send_range(5, 0, 4);
    @(negedge clk);
    check_eq("t5_ready_low", {31'd0, pix_ready}, 32'd0);
    check_eq("t5_line_pos", {22'd0, line_pos}, 32'd5);
    check_eq("t5_head_a", {3'd0, seg_valid, seg_pos, seg_size, seg_col}, {3'd0, 1'b1, desc(0, 1, 1)});
    idle_cycles(3);
    @(negedge clk);
    check_eq("t5_head_hold", {3'd0, seg_valid, seg_pos, seg_size, seg_col}, {3'd0, 1'b1, desc(0, 1, 1)});
    check_eq("t5_still_low", {31'd0, pix_ready}, 32'd0);
    @(posedge clk);
    #1;
    seg_ready = 1'b1;
    send_range(5, 5, 1023);
    idle_cycles(10);
    check_eq("t5_count", got_q.size(), 32'd1024);
    if (got_q.size() >= 3) begin
      check_eq("t5_desc0", {3'd0, got_q[0]}, {3'd0, desc(0, 1, 1)});
      check_eq("t5_desc1", {3'd0, got_q[1]}, {3'd0, desc(1, 1, 2)});
      check_eq("t5_desc2", {3'd0, got_q[2]}, {3'd0, desc(2, 1, 1)});
    end
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < got_q.size() && i < 1024; i++) begin
        if (got_q[i] !== desc(i, 1, (i % 2 == 0) ? 1 : 2)) bad++;
      end
      check_eq("t5_order_bad", bad, 32'd0);
    end

    // Reset in the middle of an open run discards it.
    got_q.delete();
    send_range(1, 0, 150);
    rst = 1'b0;
    #2;
    check_eq("t6_rst_line_pos", {22'd0, line_pos}, 32'd0);
    check_eq("t6_rst_ready", {31'd0, pix_ready}, 32'd0);
    check_eq("t6_rst_valid", {31'd0, seg_valid}, 32'd0);
    idle_cycles(2);
    rst = 1'b1;
    idle_cycles(4);
    check_eq("t6_no_desc", got_q.size(), 32'd0);
    check_eq("t6_line_pos", {22'd0, line_pos}, 32'd0);
    send_range(1, 0, 1023);
    idle_cycles(6);
    check_eq("t6_count", got_q.size(), 32'd1);
    if (got_q.size() >= 1) check_eq("t6_desc", {3'd0, got_q[0]}, {3'd0, desc(100, 100, 1)});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/segment_extractor.md
SEGMENT_EXTRACTOR -- requirements
Module: segment_extractor

Interface
REQ-001 Parameter LINE_LEN, default 1024, pixels per line; legal range 2..1024.
REQ-002 Parameter FIFO_DEPTH, default 4, descriptor FIFO entries; power of two, at least 2.
REQ-003 Port clk, input, 1, the block's only clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, asynchronous active-low reset.
REQ-005 Port pix_valid, input, 1, pixel colour available on pix_col.
REQ-006 Port pix_col, input, 8, pixel colour; 8'd0 means background.
REQ-007 Port pix_ready, output, 1, block accepts the pixel this cycle.
REQ-008 Port seg_valid, output, 1, a descriptor is presented on seg_pos, seg_size and seg_col.
REQ-009 Port seg_ready, input, 1, the consumer takes the descriptor this cycle.
REQ-010 Port seg_pos, output, 10, first pixel position of the segment.
REQ-011 Port seg_size, output, 11, segment length in pixels (1..1024).
REQ-012 Port seg_col, output, 8, segment colour (never 0).
REQ-013 Port line_pos, output, 10, position the next accepted pixel will occupy.

Function
REQ-014 A pixel is accepted when pix_valid and pix_ready are both high; there is no other consumption.
REQ-015 line_pos shall increment by 1 per accepted pixel and wrap from LINE_LEN-1 to 0.
REQ-016 FSM states: IDLE (no open run), RUN (run open: start, len, colour held), FLUSH (one pending single-pixel segment at line end).
REQ-017 IDLE, accepted col=0: stay in IDLE, no push.
REQ-018 IDLE, accepted col!=0: go to RUN with start=line_pos, len=1, colour=col.
REQ-019 RUN, accepted col equal to the run colour: len increments, no push.
REQ-020 RUN, accepted col=0: push the descriptor (start, len, colour) and go to IDLE.
REQ-021 RUN, accepted col nonzero and different: push the current descriptor, then open a new run at line_pos with len=1.
REQ-022 Line end (accepted pixel at line_pos=LINE_LEN-1): apply REQ-017..021, close any open run (push it), and go to IDLE; runs never span lines.
REQ-023 Line end, RUN, new colour different and nonzero: push the old run this cycle, then enter FLUSH.
REQ-024 In FLUSH: push (LINE_LEN-1, 1, colour) as soon as the FIFO is not full, then go to IDLE.
REQ-025 pix_ready = FIFO not full AND state != FLUSH; each cycle has at most one push, so no descriptor is ever lost.
REQ-026 A descriptor pushed in cycle N shall show seg_valid=1 in cycle N+1 or later.
REQ-027 The FIFO is first-word-fallthrough: seg_valid = FIFO not empty.
REQ-028 The FIFO pops on seg_valid & seg_ready.
REQ-029 If the FIFO is full, a push and a pop may occur in the same cycle.
REQ-030 Descriptors leave in the order they were produced.
REQ-031 seg_pos, seg_size and seg_col shall hold stable while seg_valid=1 and seg_ready=0.

Reset
REQ-032 While rst=0, regardless of clk: state=IDLE, line_pos=0, run registers=0, FIFO empty.
REQ-033 While rst=0: seg_valid=0, seg_pos=0, seg_size=0, seg_col=0, pix_ready=0.
REQ-034 After rst rises, the block behaves as at line start; a run open when reset asserted is discarded and never emitted.

Structure
REQ-035 A shared package seg_pkg shall hold the position width (10), size width (11), colour width (8), the FSM state encoding, and the descriptor record (pos, size, col, 29 bits total).
REQ-036 The descriptor FIFO shall be a separate sub-module, seg_fifo (synchronous, parameterised depth and width, full/empty flags).

Verification
REQ-037 Colour 1 at positions 100..199, 0 elsewhere, seg_ready=1 -> exactly one descriptor (100, 100, 1) per line.
REQ-038 Colour 2 at 50..99 then colour 1 at 100..199, 0 elsewhere -> (50, 50, 2) then (100, 100, 1), with no gap descriptor.
REQ-039 Whole line colour 3 -> (0, 1024, 3), emitted after the pixel at 1023 is accepted; next line starts at line_pos=0.
REQ-040 Colour 1 at 1000..1022, colour 2 at 1023 -> (1000, 23, 1) then (1023, 1, 2); pix_ready=0 for the FLUSH cycle.
REQ-041 seg_ready=0, alternating colours 1/2 per pixel from position 0 -> pix_ready falls after 4 descriptors are queued; releasing seg_ready yields (0,1,1), (1,1,2), (2,1,1) and so on, in order and without loss.
REQ-042 Reset pulse during the colour-1 run at position 150 -> no descriptor for that run; line_pos=0 after reset.
